// File: rtl/sr_latch_arbiter_if.sv
// Requester-side bundle for the shared SR latch arbiter.
// Requesters use the master modport, and the arbiter uses the slave modport.
interface sr_latch_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic [N-1:0] op;
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
    logic         err;

    modport master (output req, op, input gnt, ack, err);
    modport slave  (input req, op, output gnt, ack, err);
endinterface

// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter that serialises set/reset writes from N requesters onto one SR latch.
// It reads the latch back after each write and flags a mismatch.
module sr_latch_arbiter #(
    parameter int N    = 4,
    parameter int HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sr_latch_arbiter_if.slave    bus,
    output logic                 S,
    output logic                 R,
    output logic                 enable,
    input  logic                 Q,
    input  logic                 Qn,
    output logic                 busy,
    output logic [7:0]           err_cnt
);
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, ACK} state_t;

    localparam int W = $clog2(N);
    localparam logic [W-1:0] LAST      = W'(N - 1);
    localparam logic [3:0]   HOLD_LAST = 4'(HOLD - 1);

    state_t         state, state_n;
    logic [W-1:0]   ptr, ptr_n, w, w_n, pick;
    logic           found;
    logic           op_q, op_n;
    logic [3:0]     cnt, cnt_n;
    logic [N-1:0]   gnt_n, ack_n;
    logic           err_n, s_n, r_n, en_n;
    logic [7:0]     err_cnt_n;

    always_comb begin : rr_pick
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && bus.req[W'(idx)]) begin
                found = 1'b1;
                pick  = W'(idx);
            end
        end
    end

    always_comb begin
        state_n = state;
        w_n     = w;
        op_n    = op_q;
        cnt_n   = cnt;
        ptr_n   = ptr;
        case (state)
            IDLE: if (found) begin
                w_n     = pick;
                op_n    = bus.op[pick];
                cnt_n   = '0;
                state_n = DRIVE;
            end
            DRIVE: if (cnt == HOLD_LAST) begin
                cnt_n   = '0;
                state_n = SETTLE;
            end else begin
                cnt_n = cnt + 4'd1;
            end
            SETTLE: state_n = ACK;
            ACK: begin
                ptr_n   = (w == LAST) ? '0 : w + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        gnt_n = '0;
        ack_n = '0;
        s_n   = 1'b0;
        r_n   = 1'b0;
        en_n  = 1'b0;
        err_n = (state == SETTLE) && ((Q != op_q) || (Qn == Q));
        case (state_n)
            DRIVE: begin
                gnt_n[w_n] = 1'b1;
                en_n       = 1'b1;
                s_n        = op_n;
                r_n        = ~op_n;
            end
            SETTLE:  gnt_n[w_n] = 1'b1;
            ACK:     ack_n[w_n] = 1'b1;
            default: ;
        endcase
        err_cnt_n = (err_n && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            w       <= '0;
            op_q    <= 1'b0;
            cnt     <= '0;
            err_cnt <= '0;
            bus.gnt <= '0;
            bus.ack <= '0;
            bus.err <= 1'b0;
            S       <= 1'b0;
            R       <= 1'b0;
            enable  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            w       <= w_n;
            op_q    <= op_n;
            cnt     <= cnt_n;
            err_cnt <= err_cnt_n;
            bus.gnt <= gnt_n;
            bus.ack <= ack_n;
            bus.err <= err_n;
            S       <= s_n;
            R       <= r_n;
            enable  <= en_n;
            busy    <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Directed bench for sr_latch_arbiter with a behavioural SR latch that can be stuck at Q=0.
module tb_sr_latch_arbiter;
    localparam int N    = 4;
    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       S, R, enable, Q, Qn, busy;
    logic [7:0] err_cnt;
    logic       q_l = 1'b0;
    logic       stuck = 1'b0;
    int         total = 0;
    int         bad = 0;

    sr_latch_arbiter_if #(.N(N)) bus();

    sr_latch_arbiter #(.N(N), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .S       (S),
        .R       (R),
        .enable  (enable),
        .Q       (Q),
        .Qn      (Qn),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // Level latch, updated mid-cycle while enable is high.
    always @(negedge clk) begin
        if (enable && S)      q_l <= 1'b1;
        else if (enable && R) q_l <= 1'b0;
    end
    assign Q  = stuck ? 1'b0 : q_l;
    assign Qn = ~Q;

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((S && R) || !$onehot0(bus.gnt) || !$onehot0(bus.ack) ||
                (bus.err && !(|bus.ack)) || (!S && !R && enable)) begin
                bad++;
                $display("FAIL invariant: S=%b R=%b en=%b gnt=%b ack=%b err=%b",
                         S, R, enable, bus.gnt, bus.ack, bus.err);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.op  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.op  = 4'b1111;
        tick();
        total++;
        if ({bus.gnt, bus.ack, bus.err, S, R, enable, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%b ack=%b err=%b S=%b R=%b en=%b busy=%b, need all 0",
                     bus.gnt, bus.ack, bus.err, S, R, enable, busy);
        end
        total++;
        if (err_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_err_cnt: got %0d need 0", err_cnt);
        end
        bus.req = '0;
        bus.op  = '0;
        rst_n   = 1'b1;
    endtask

    task automatic test_single_set;
        do_reset();
        bus.req = 4'b0001;
        bus.op  = 4'b0001;
        tick();  // cycle 1
        bus.req = '0;
        total++;
        if (bus.gnt !== 4'b0001 || enable !== 1'b1 || S !== 1'b1 || R !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL set_c1: gnt=%b en=%b S=%b R=%b busy=%b need 0001 1 1 0 1", bus.gnt, enable, S, R, busy);
        end
        tick();  // cycle 2
        total++;
        if (bus.gnt !== 4'b0001 || enable !== 1'b1 || S !== 1'b1) begin
            bad++;
            $display("FAIL set_c2: gnt=%b en=%b S=%b need 0001 1 1", bus.gnt, enable, S);
        end
        tick();  // cycle 3 settle
        total++;
        if (bus.gnt !== 4'b0001 || enable !== 1'b0 || S !== 1'b0 || R !== 1'b0 || bus.ack !== 4'b0000) begin
            bad++;
            $display("FAIL set_settle: gnt=%b en=%b S=%b R=%b ack=%b need 0001 0 0 0 0000",
                     bus.gnt, enable, S, R, bus.ack);
        end
        tick();  // cycle 4 ack
        total++;
        if (bus.ack !== 4'b0001 || bus.err !== 1'b0 || bus.gnt !== 4'b0000 || Q !== 1'b1) begin
            bad++;
            $display("FAIL set_ack: ack=%b err=%b gnt=%b Q=%b need 0001 0 0000 1", bus.ack, bus.err, bus.gnt, Q);
        end
        tick();  // cycle 5 idle
        total++;
        if (bus.ack !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL set_idle: ack=%b busy=%b need 0000 0", bus.ack, busy);
        end
    endtask

    task automatic test_contention;
        logic [N-1:0] acks [5];
        int           cycs [5];
        int           n = 0;
        logic         s_seen = 1'b0;
        do_reset();
        bus.req = 4'b1111;
        bus.op  = 4'b0000;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (S) s_seen = 1'b1;
            if (bus.ack !== '0 && n < 5) begin
                acks[n] = bus.ack;
                cycs[n] = c;
                n++;
                total++;
                if (bus.err !== 1'b0) begin
                    bad++;
                    $display("FAIL contention_err: got %b need 0 at cycle %0d", bus.err, c);
                end
            end
        end
        bus.req = '0;
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL contention_count: got %0d acks need 5", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (acks[i] !== 4'(1 << (i % 4)) || cycs[i] != 4 + 5 * i) begin
                bad++;
                $display("FAIL contention_order[%0d]: got ack=%b at %0d need %b at %0d",
                         i, acks[i], cycs[i], 4'(1 << (i % 4)), 4 + 5 * i);
            end
        end
        total++;
        if (s_seen !== 1'b0) begin
            bad++;
            $display("FAIL contention_S: got S=1 seen, need never");
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        bus.req = 4'b0011;
        bus.op  = 4'b0000;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 4 || c == 9 || c == 14) begin
                total++;
                if (bus.ack !== ((c == 9) ? 4'b0010 : 4'b0001)) begin
                    bad++;
                    $display("FAIL b2b_ack_c%0d: got %b need %b", c, bus.ack, (c == 9) ? 4'b0010 : 4'b0001);
                end
            end
        end
        bus.req = '0;
        repeat (6) tick();
    endtask

    task automatic test_fault;
        do_reset();
        stuck   = 1'b1;
        bus.req = 4'b0100;
        bus.op  = 4'b0100;
        for (int c = 1; c <= 1500; c++) begin
            tick();
            if (c == 4) begin
                total++;
                if (bus.ack !== 4'b0100 || bus.err !== 1'b1) begin
                    bad++;
                    $display("FAIL fault_ack: ack=%b err=%b need 0100 1", bus.ack, bus.err);
                end
            end
            if (c == 5) begin
                total++;
                if (err_cnt !== 8'd1) begin
                    bad++;
                    $display("FAIL fault_cnt1: got %0d need 1", err_cnt);
                end
            end
            if (c == 1273) begin
                total++;
                if (err_cnt !== 8'd254) begin
                    bad++;
                    $display("FAIL fault_cnt254: got %0d need 254", err_cnt);
                end
            end
            if (c == 1275 || c == 1500) begin
                total++;
                if (err_cnt !== 8'd255) begin
                    bad++;
                    $display("FAIL fault_sat_c%0d: got %0d need 255", c, err_cnt);
                end
            end
        end
        bus.req = '0;
        stuck   = 1'b0;
    endtask

    task automatic test_midop;
        do_reset();
        bus.req = 4'b0001;
        bus.op  = 4'b0001;
        tick();  // cycle 1
        tick();  // cycle 2
        bus.op  = 4'b0000;
        bus.req = 4'b0000;
        total++;
        if (S !== 1'b1 || R !== 1'b0) begin
            bad++;
            $display("FAIL midop_c2: S=%b R=%b need 1 0", S, R);
        end
        tick();  // cycle 3
        total++;
        if (bus.gnt !== 4'b0001 || S !== 1'b0 || R !== 1'b0) begin
            bad++;
            $display("FAIL midop_settle: gnt=%b S=%b R=%b need 0001 0 0", bus.gnt, S, R);
        end
        tick();  // cycle 4
        total++;
        if (bus.ack !== 4'b0001 || bus.err !== 1'b0 || Q !== 1'b1) begin
            bad++;
            $display("FAIL midop_ack: ack=%b err=%b Q=%b need 0001 0 1", bus.ack, bus.err, Q);
        end
        tick();
    endtask

    task automatic test_reset_drive;
        logic qb;
        do_reset();
        bus.req = 4'b0100;
        bus.op  = 4'b0100;
        tick();
        bus.req = '0;
        tick();
        tick();
        tick();  // cycle 4
        total++;
        if (bus.ack !== 4'b0100) begin
            bad++;
            $display("FAIL rd_first_ack: got %b need 0100", bus.ack);
        end
        tick();  // idle, new cycle 0
        bus.req = 4'b0001;
        bus.op  = 4'b0001;
        tick();  // cycle 1
        tick();  // cycle 2
        bus.req = '0;
        qb      = Q;
        rst_n   = 1'b0;
        #1;
        total++;
        if ({S, R, enable, bus.gnt, busy} !== '0) begin
            bad++;
            $display("FAIL rd_async: S=%b R=%b en=%b gnt=%b busy=%b need all 0", S, R, enable, bus.gnt, busy);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (bus.ack !== 4'b0000 || Q !== qb) begin
                bad++;
                $display("FAIL rd_hold_%0d: ack=%b Q=%b need 0000 %b", c, bus.ack, Q, qb);
            end
        end
        rst_n   = 1'b1;
        bus.req = 4'b1010;
        bus.op  = 4'b0000;
        tick();
        bus.req = '0;
        total++;
        if (bus.gnt !== 4'b0010) begin
            bad++;
            $display("FAIL rd_regrant: got %b need 0010", bus.gnt);
        end
        repeat (5) tick();
    endtask

    initial begin
        bus.req = '0;
        bus.op  = '0;
        test_reset();
        test_single_set();
        test_contention();
        test_back_to_back();
        test_fault();
        test_midop();
        test_reset_drive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_latch_arbiter.md
SR_LATCH_ARBITER -- requirements
Module: sr_latch_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter HOLD, default 2, number of enable-active cycles per write (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  N  per-requester access request, level.
REQ-006 SHALL have port op  input  N  per-requester operation: 1 = set, 0 = reset.
REQ-007 SHALL have port gnt  output  N  one-hot grant, high for the whole transaction.
REQ-008 SHALL have port ack  output  N  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port err  output  1  one-cycle pulse coincident with ack when readback mismatches.
REQ-010 SHALL have port S  output  1  set drive to the shared SR latch.
REQ-011 SHALL have port R  output  1  reset drive to the shared SR latch.
REQ-012 SHALL have port enable  output  1  enable drive to the shared SR latch.
REQ-013 SHALL have port Q  input  1  latch true output, readback.
REQ-014 SHALL have port Qn  input  1  latch inverted output, readback.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port err_cnt  output  8  saturating count of err pulses.

Function
REQ-017 SHALL implement FSM states IDLE, DRIVE, SETTLE, ACK; all outputs registered.
REQ-018 IDLE: if any req bit high, SHALL select the winner by round-robin starting at pointer ptr, latch winner index w and op[w], go DRIVE; otherwise stay IDLE.
REQ-019 DRIVE: SHALL hold gnt[w]=1, enable=1, S=op_q, R=~op_q for exactly HOLD cycles (4-bit counter), then go SETTLE.
REQ-020 SETTLE: SHALL drive enable=0, S=0, R=0, keep gnt[w]=1, and sample Q and Qn at the end of the cycle; go ACK.
REQ-021 ACK: SHALL pulse ack[w]=1 for one cycle, drop gnt, set ptr=(w+1) mod N, go IDLE.
REQ-022 err SHALL pulse with ack when sampled Q != op_q or sampled Qn == sampled Q.
REQ-023 err_cnt SHALL increment on each err pulse and saturate at 255.
REQ-024 Latency: req sampled in IDLE at cycle t -> gnt/enable high t+1..t+HOLD, SETTLE t+HOLD+1, ack t+HOLD+2, IDLE t+HOLD+3.
REQ-025 S and R SHALL never both be 1 in any cycle; enable SHALL be 0 whenever S=R=0.
REQ-026 op SHALL be sampled only at grant; op changes during a transaction SHALL be ignored.
REQ-027 req dropping mid-transaction SHALL NOT abort it; the transaction completes and ack still pulses.
REQ-028 A requester holding req through ack SHALL be re-eligible in the next IDLE but SHALL rank behind the others via ptr.
REQ-029 Simultaneous requests SHALL be granted one at a time; no requester waits more than N-1 transactions.
REQ-030 ptr wrap: w=N-1 SHALL set ptr=0.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, ptr=0, counter=0, err_cnt=0, gnt=0, ack=0, err=0, S=0, R=0, enable=0, busy=0.
REQ-032 Reset mid-transaction SHALL abort without ack; the latch keeps its last value; first grant after release follows ptr=0.

Verification
REQ-033 Single set: HOLD=2, req=0001, op=0001 at cycle 0 -> gnt=0001, enable=1, S=1 cycles 1-2; ack=0001 cycle 4; Q=1, err=0.
REQ-034 Contention: req=1111 held, all op=0 -> ack order 0001, 0010, 0100, 1000, 0001; each 5 cycles apart; S never 1.
REQ-035 Fault: latch model stuck Q=0, requester 2 sets -> ack=0100 with err=1; err_cnt increments by 1; after 300 faults err_cnt=255.
REQ-036 Mid-op changes: op[0] toggles and req[0] drops in cycle 2 -> S stays 1 through DRIVE, ack[0] still pulses cycle 4.
REQ-037 Reset in DRIVE: rst_n low cycle 2 -> S=R=enable=gnt=0 same cycle, no ack; Q keeps its value; next req=1010 grants 0010 first.
REQ-038 Assertions every cycle: !(S&&R), $onehot0(gnt), $onehot0(ack), err implies |ack.
